serial_adder_stage: RTL and testbench
=====================================

# serial_adder_stage

Bit-serial adder stage that sits directly downstream of the single-bit sum/carry logic in the adder datapath. It accepts two operands one bit per cycle, LSB first, and feeds each carry back through a carry register. It re-serialises the sum bits and assembles them into a parallel WIDTH-bit result with a final carry-out. A start/busy/done handshake frames each addition.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  reset, synchronous, active-high
- start  input  1  begin a new addition; honoured only in IDLE
- bit_valid  input  1  a_bit/b_bit carry a valid operand bit this cycle
- a_bit  input  1  operand A bit, LSB first
- b_bit  input  1  operand B bit, LSB first
- sum_bit  output  1  registered sum bit of the last accepted bit pair
- sum_bit_valid  output  1  one-cycle pulse, cycle after each accepted bit
- result  output  WIDTH  assembled sum, bit i = sum of operand bit i
- carry_out  output  1  final carry of the completed addition
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse, result/carry_out complete

## Operation
- States: IDLE, SHIFT, DONE. Encoding is free.
- Reset (rst=1 at a clock edge):
  - State → IDLE; carry register, bit counter, result, sum_bit, carry_out → 0.
  - sum_bit_valid, busy, done → 0.
  - Reset overrides every other input, including mid-addition. A partial addition is discarded.
- IDLE:
  - start=1: → SHIFT; carry register ← 0, counter ← 0, result ← 0.
  - bit_valid is ignored in IDLE, including in the same cycle as start.
- SHIFT:
  - bit_valid=1 accepts one bit pair:
    - s = a_bit ^ b_bit ^ c
    - c ← (a_bit&b_bit) | (c&(a_bit^b_bit))
    - result ← {s, result[WIDTH-1:1]}
    - sum_bit ← s; sum_bit_valid pulses next cycle
    - counter increments
  - bit_valid=0 is a stall. No state changes; sum_bit holds its value.
  - When the accepted bit is number WIDTH-1 (counter==WIDTH-1): carry_out ← new carry, → DONE.
- DONE: done=1 for exactly this cycle, then → IDLE unconditionally. start and bit_valid are ignored in DONE.
- start while busy is ignored and is not queued.
- result and carry_out hold after DONE until the next honoured start. start clears result; it does not clear carry_out.
- Arithmetic: {carry_out, result} = A + B mod 2^(WIDTH+1). There is no overflow flag beyond carry_out.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- start sampled at edge t → busy=1 from t+1. The earliest first bit is accepted at edge t+1.
- With no stalls: bits are accepted at edges t+1..t+WIDTH, and done=1 in cycle t+WIDTH+1. Minimum start-to-done latency is WIDTH+1 cycles.
- Each stall cycle adds exactly one cycle of latency.
- sum_bit/sum_bit_valid appear one cycle after the edge that accepted the bit.
- result and carry_out are valid in the cycle done=1 and stay valid afterwards.
- busy drops to 0 the cycle after done. A start in that cycle is honoured, giving back-to-back additions every WIDTH+2 cycles.

## Test plan
- Reset: assert rst for 2 cycles with start=1 and bit_valid=1. Every output must be 0 and busy must stay 0.
- Basic add, WIDTH=8: A=0x5A, B=0x3C, no stalls. Required response:
  - done exactly 9 cycles after start
  - result=0x96, carry_out=0
  - sum_bit stream LSB first: 0,1,1,0,1,0,0,1
- Carry propagation: A=0xFF, B=0x01 → result=0x00, carry_out=1. Then A=0x00, B=0x00 → result=0x00, carry_out=0, showing that start clears the carry.
- Stalls: A=0x81, B=0x81, with bit_valid low for 3 random cycles. Required response:
  - result=0x02, carry_out=1
  - done 12 cycles after start
  - exactly 8 sum_bit_valid pulses
- Protocol: start pulsed in SHIFT and DONE is ignored, and the result is unchanged. A start together with bit_valid in IDLE drops that bit, and the operand then completes correctly from the next cycle.
- Mid-operation reset: rst after 4 accepted bits → IDLE with all outputs 0 and no done pulse. A fresh addition of 0x0F+0x01 then gives 0x10, carry_out=0.

Source files
------------

// File: rtl/serial_adder_stage.sv
// Bit-serial adder stage: adds two LSB-first operand streams through a carry register,
// echoes each sum bit and assembles the parallel WIDTH-bit result plus final carry-out.
module serial_adder_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             sum_bit,
    output logic             sum_bit_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          carry;
    logic [CW-1:0] count;
    logic          accept;
    logic          sum_now;
    logic          carry_now;

    always_comb begin
        accept    = (state == SHIFT) && bit_valid;
        sum_now   = a_bit ^ b_bit ^ carry;
        carry_now = (a_bit & b_bit) | (carry & (a_bit ^ b_bit));
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (accept && (count == LAST)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // busy/done are flopped from the next state so they line up with the state register
    always_ff @(posedge clk) begin
        if (rst) begin
            carry         <= 1'b0;
            count         <= '0;
            result        <= '0;
            sum_bit       <= 1'b0;
            sum_bit_valid <= 1'b0;
            carry_out     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            sum_bit_valid <= accept;
            busy          <= (next_state != IDLE);
            done          <= (next_state == DONE);
            if ((state == IDLE) && start) begin
                carry  <= 1'b0;
                count  <= '0;
                result <= '0;
            end else if (accept) begin
                carry   <= carry_now;
                count   <= count + 1'b1;
                result  <= {sum_now, result[WIDTH-1:1]};
                sum_bit <= sum_now;
                if (count == LAST) carry_out <= carry_now;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_stage.sv
// Self-checking bench for serial_adder_stage: directed and randomised additions
// compared against plain integer addition of the operands.
module tb_serial_adder_stage;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         bit_valid;
    logic         a_bit;
    logic         b_bit;
    logic         sum_bit;
    logic         sum_bit_valid;
    logic [W-1:0] result;
    logic         carry_out;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;
    int done_count = 0;
    logic sb_q[$];

    serial_adder_stage #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .bit_valid     (bit_valid),
        .a_bit         (a_bit),
        .b_bit         (b_bit),
        .sum_bit       (sum_bit),
        .sum_bit_valid (sum_bit_valid),
        .result        (result),
        .carry_out     (carry_out),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Records the previous cycle's output pulses at each rising edge
    always @(posedge clk) begin
        if (sum_bit_valid) sb_q.push_back(sum_bit);
        if (done) done_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outputs"},
              {22'd0, sum_bit, sum_bit_valid, result, carry_out, busy, done},
              32'd0);
    endtask

    // One addition starting at the current negedge; the reference is a + b as a 9-bit sum
    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input int n_stall,
                           input bit poke_start, input bit idle_bit);
        int          stall_at[W];
        int          cyc;
        int          dc0;
        logic [W:0]  exp_sum;
        logic        prev_co;
        logic [W-1:0] got;
        exp_sum = {1'b0, a} + {1'b0, b};
        foreach (stall_at[k]) stall_at[k] = 0;
        for (int s = 0; s < n_stall; s++) stall_at[$urandom_range(0, W-1)]++;
        prev_co = carry_out;
        sb_q.delete();
        dc0 = done_count;

        start = 1'b1; bit_valid = idle_bit; a_bit = 1'b1; b_bit = 1'b1;
        @(negedge clk);
        cyc = 1;
        start = 1'b0; bit_valid = 1'b0;
        check("busy_after_start", busy, 1);
        check("carry_out_kept_by_start", carry_out, prev_co);
        check("result_cleared_by_start", result, 0);

        for (int k = 0; k < W; k++) begin
            for (int s = 0; s < stall_at[k]; s++) begin
                bit_valid = 1'b0; a_bit = 1'($urandom); b_bit = 1'($urandom);
                start = poke_start;
                @(negedge clk);
                cyc++;
                check("stall_no_pulse", sum_bit_valid, 0);
            end
            bit_valid = 1'b1; a_bit = a[k]; b_bit = b[k];
            start = poke_start && ($urandom_range(0, 1) == 1);
            @(negedge clk);
            cyc++;
            check("done_timing", done, (k == W-1));
        end
        bit_valid = 1'b0; start = poke_start;
        check("latency", cyc, W + 1 + n_stall);
        check("result", result, exp_sum[W-1:0]);
        check("carry_out", carry_out, exp_sum[W]);
        check("busy_in_done", busy, 1);

        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("busy_dropped", busy, 0);
        check("result_held", result, exp_sum[W-1:0]);
        check("carry_out_held", carry_out, exp_sum[W]);
        check("sum_pulse_count", sb_q.size(), W);
        check("done_pulse_count", done_count - dc0, 1);
        got = '0;
        foreach (sb_q[j]) if (j < W) got[j] = sb_q[j];
        check("sum_stream", got, exp_sum[W-1:0]);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_all_zero("reset");
        end
        rst = 1'b0; start = 1'b0; bit_valid = 1'b0;
        @(negedge clk);
        check("idle_after_reset_busy", busy, 0);

        run_add(8'h5A, 8'h3C, 0, 1'b0, 1'b0);
        run_add(8'hFF, 8'h01, 0, 1'b0, 1'b0);
        run_add(8'h00, 8'h00, 0, 1'b0, 1'b0);
        run_add(8'h81, 8'h81, 3, 1'b0, 1'b0);
        run_add(8'hC3, 8'h7E, 1, 1'b1, 1'b0);
        run_add(8'h37, 8'h19, 0, 1'b0, 1'b1);

        // Abort an addition after four accepted bits
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'(k & 1);
            @(negedge clk);
        end
        bit_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        rst = 1'b0;
        begin
            int dc0;
            dc0 = done_count;
            repeat (12) @(negedge clk);
            check("mid_reset_no_done", done_count - dc0, 0);
            check("mid_reset_idle", busy, 0);
        end
        run_add(8'h0F, 8'h01, 0, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++)
            run_add(8'($urandom), 8'($urandom), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
